// File: rtl/fb_pixel_writer_pkg.sv
// Shared frame-buffer geometry, pixel-code type and writer FSM states.
package fb_pkg;

  localparam int H_PIXELS = 640;
  localparam int V_PIXELS = 480;
  localparam int FB_DEPTH = H_PIXELS * V_PIXELS;
  localparam int DATA_W   = 3;
  localparam int ADDR_W   = 19;
  localparam int SUM_W    = 24;

  typedef logic [DATA_W-1:0] pix_code_t;

  typedef enum logic [1:0] {
    CLEAR,
    WAIT_SOF,
    WRITE
  } wr_state_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Raster pixel-code stream from the renderer into the frame-buffer writer (valid/ready, SOF marker).
interface fb_pixel_writer_if #(
  parameter int DATA_W = fb_pkg::DATA_W
);

  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;

  modport master (output pix_valid, output pix_sof, output pix_data, input  pix_ready);
  modport slave  (input  pix_valid, input  pix_sof, input  pix_data, output pix_ready);

endinterface

// File: rtl/fb_pixel_writer_addr_counter.sv
// Frame-buffer address counter shared by the zero-fill and pixel-write paths.
// load0 forces the base to 0 before an optional increment; increments wrap after DEPTH-1.
module fb_addr_counter #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DEPTH  = fb_pkg::FB_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load0,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] base;

  assign base = load0 ? '0 : addr;
  assign last = (addr == LAST_ADDR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (inc) begin
      addr <= (base == LAST_ADDR) ? '0 : base + 1'b1;
    end else begin
      addr <= base;
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write side: zero-fill, then raster pixel writes; BRAM write one cycle after accept.
// pix_ready is low only while clearing; optional frame checksum output under FB_WRITER_CHECKSUM_EN.
module fb_pixel_writer #(
  parameter int H_PIXELS = fb_pkg::H_PIXELS,
  parameter int V_PIXELS = fb_pkg::V_PIXELS,
  parameter int DATA_W   = fb_pkg::DATA_W,
  parameter int ADDR_W   = fb_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  fb_pixel_writer_if.slave  pix,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              ready,
  output logic              busy,
  output logic              sof_err,
  output logic [15:0]       frame_count
`ifdef FB_WRITER_CHECKSUM_EN
  ,
  output logic [23:0]       frame_sum
`endif
);

  import fb_pkg::*;

  localparam int FRAME_PIX = H_PIXELS * V_PIXELS;

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              load0;
  logic              inc;
  logic              accept;
  logic              pix_wr;
  logic              restart;
  logic              frame_done;

  fb_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FRAME_PIX)
  ) u_addr (
    .clock   (clock),
    .reset_n (reset_n),
    .load0   (load0),
    .inc     (inc),
    .addr    (addr),
    .last    (last)
  );

  assign pix.pix_ready = (state != CLEAR);
  assign busy          = (state != WAIT_SOF);
  assign accept        = pix.pix_valid & pix.pix_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load0      = 1'b0;
    inc        = 1'b0;
    pix_wr     = 1'b0;
    restart    = 1'b0;
    frame_done = 1'b0;
    case (state)
      CLEAR: begin
        inc = 1'b1;
        if (last) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (accept && pix.pix_sof) begin
          pix_wr    = 1'b1;
          restart   = 1'b1;
          load0     = 1'b1;
          inc       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          pix_wr = 1'b1;
          inc    = 1'b1;
          // An SOF inside a frame wins over frame completion: restart at address 0.
          if (pix.pix_sof) begin
            restart = 1'b1;
            load0   = 1'b1;
          end else if (last) begin
            frame_done = 1'b1;
            state_nxt  = WAIT_SOF;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
    // Clear overrides everything except the write of a pixel accepted this cycle.
    if (clear_req) begin
      state_nxt = CLEAR;
      load0     = 1'b1;
      inc       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      ready       <= 1'b0;
      sof_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      bram_we   <= (state == CLEAR) | pix_wr;
      bram_addr <= restart ? '0 : addr;
      bram_din  <= pix_wr ? pix.pix_data : '0;
      if (restart && (state == WRITE) && (addr != '0)) sof_err <= 1'b1;
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (clear_req) begin
        ready <= 1'b0;
      end else if (frame_done) begin
        ready <= 1'b1;
      end
    end
  end

`ifdef FB_WRITER_CHECKSUM_EN
  logic [SUM_W-1:0] run_sum;

  always_ff @(posedge clock) begin
    if (!reset_n || clear_req) begin
      run_sum   <= '0;
      frame_sum <= '0;
    end else if (pix_wr) begin
      run_sum <= restart ? SUM_W'(pix.pix_data) : run_sum + SUM_W'(pix.pix_data);
      if (frame_done) frame_sum <= run_sum + SUM_W'(pix.pix_data);
    end
  end
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on a reduced 16x8 buffer; vector table plus multi-cycle sequences.
module tb_fb_pixel_writer;

  import fb_pkg::*;

  localparam int TB_H  = 16;
  localparam int TB_V  = 8;
  localparam int DEPTH = TB_H * TB_V;
  localparam int AW    = 7;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear_req = 1'b0;
  logic            bram_we;
  logic [AW-1:0]   bram_addr;
  pix_code_t       bram_din;
  logic            ready;
  logic            busy;
  logic            sof_err;
  logic [15:0]     frame_count;
`ifdef FB_WRITER_CHECKSUM_EN
  logic [23:0]     frame_sum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fb_pixel_writer_if #(.DATA_W(DATA_W)) pix();

  fb_pixel_writer #(
    .H_PIXELS (TB_H),
    .V_PIXELS (TB_V),
    .DATA_W   (DATA_W),
    .ADDR_W   (AW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_req   (clear_req),
    .pix         (pix),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .ready       (ready),
    .busy        (busy),
    .sof_err     (sof_err),
    .frame_count (frame_count)
`ifdef FB_WRITER_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  typedef struct {
    logic          v;
    logic          s;
    pix_code_t     d;
    logic          we;
    logic [AW-1:0] addr;
    pix_code_t     din;
    logic          busy;
    logic          err;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input int d, input logic c);
    pix.pix_valid = v;
    pix.pix_sof   = s;
    pix.pix_data  = 3'(d);
    clear_req     = c;
  endtask

  task automatic reset_and_clear();
    int busy_cnt;
    int wr_cnt;
    int bad;
    busy_cnt = 0;
    wr_cnt   = 0;
    bad      = 0;
    drive(0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_ready", ready, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_pix_ready", pix.pix_ready, 0);
`ifdef FB_WRITER_CHECKSUM_EN
    chk("rst_frame_sum", frame_sum, 0);
`endif
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (busy) busy_cnt++;
      if (bram_we) begin
        if (bram_addr != AW'(wr_cnt) || bram_din != 3'd0) bad++;
        wr_cnt++;
      end
      @(negedge clock);
    end
    chk("clear_busy_cycles", busy_cnt, DEPTH);
    chk("clear_writes", wr_cnt, DEPTH);
    chk("clear_addr_seq", bad, 0);
    chk("idle_pix_ready", pix.pix_ready, 1);
    chk("idle_ready", ready, 0);
  endtask

  // Sends n back-to-back pixels whose data is (address % 8); checks each write one cycle later.
  task automatic send_pixels(input int start, input int n, input logic first_sof, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      drive(1, first_sof && (k == 0), (start + k) % 8, 0);
      @(negedge clock);
      if (!bram_we || bram_addr != AW'(start + k) || bram_din != 3'((start + k) % 8)) bad++;
    end
    drive(0, 0, 0, 0);
    chk(name, bad, 0);
  endtask

  initial begin
    int   bad;
    int   n;
    int   sent;
    int   iter;
    logic v;

    tbl[0] = '{1, 0, 5, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 3, 1, 0, 3, 1, 0};
    tbl[3] = '{1, 0, 4, 1, 1, 4, 1, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 6, 1, 2, 6, 1, 0};
    tbl[6] = '{1, 1, 2, 1, 0, 2, 1, 1};
    tbl[7] = '{1, 0, 1, 1, 1, 1, 1, 1};

    reset_and_clear();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].s, int'(tbl[i].d), 0);
      @(negedge clock);
      chk($sformatf("vec%0d_we", i), bram_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), bram_addr, tbl[i].addr);
        chk($sformatf("vec%0d_din", i), bram_din, tbl[i].din);
      end
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_sof_err", i), sof_err, tbl[i].err);
    end
    drive(0, 0, 0, 0);

    reset_and_clear();

    // Pixels without SOF while waiting are dropped, then a full frame.
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, k + 1, 0);
      @(negedge clock);
      if (bram_we) bad++;
    end
    chk("nosof_dropped", bad, 0);
    send_pixels(0, DEPTH - 1, 1, "frame1_body");
    chk("frame1_ready_pre", ready, 0);
    send_pixels(DEPTH - 1, 1, 0, "frame1_last");
    chk("frame1_ready", ready, 1);
    chk("frame1_count", frame_count, 1);
    chk("frame1_idle", busy, 0);

    // SOF in mid-frame restarts at address 0 and latches sof_err.
    send_pixels(0, 50, 1, "frame2_head");
    chk("frame2_err_pre", sof_err, 0);
    send_pixels(0, 1, 1, "frame2_restart");
    chk("frame2_err", sof_err, 1);
    chk("frame2_count_hold", frame_count, 1);
    send_pixels(1, DEPTH - 1, 0, "frame2_rest");
    chk("frame2_count", frame_count, 2);
    chk("frame2_ready", ready, 1);

    // clear_req with an accepted pixel: pixel still written, ready drops, fill starts at 0.
    send_pixels(0, 80, 1, "frame3_head");
    drive(1, 0, 80 % 8, 1);
    @(negedge clock);
    chk("clr_pix_we", bram_we, 1);
    chk("clr_pix_addr", bram_addr, 80);
    chk("clr_ready_drop", ready, 0);
    chk("clr_pix_ready", pix.pix_ready, 0);
    chk("clr_busy", busy, 1);
    drive(0, 0, 0, 0);
    @(negedge clock);
    chk("fill_first_we", bram_we, 1);
    chk("fill_first_addr", bram_addr, 0);
    chk("fill_first_din", bram_din, 0);
    repeat (8) @(negedge clock);
    chk("fill_progress", bram_addr, 8);
    drive(0, 0, 0, 1);
    @(negedge clock);
    drive(0, 0, 0, 0);
    @(negedge clock);
    chk("refill_addr", bram_addr, 0);
    n = 0;
    while (!pix.pix_ready && n < DEPTH + 16) begin
      @(negedge clock);
      n++;
    end
    chk("fill_done", pix.pix_ready, 1);
    chk("ready_after_clear", ready, 0);
    send_pixels(0, DEPTH - 1, 1, "frame4_body");
    chk("frame4_ready_pre", ready, 0);
    send_pixels(DEPTH - 1, 1, 0, "frame4_last");
    chk("frame4_ready", ready, 1);
    chk("frame4_count", frame_count, 3);

    // Random valid gaps, all codes 7: no write on idle cycles.
    bad  = 0;
    sent = 0;
    iter = 0;
    while (sent < DEPTH && iter < DEPTH * 10) begin
      v = 1'($urandom_range(0, 1));
      drive(v, v && (sent == 0), 7, 0);
      @(negedge clock);
      iter++;
      if (v) begin
        if (!bram_we || bram_addr != AW'(sent) || bram_din != 3'd7) bad++;
        sent++;
      end else if (bram_we) begin
        bad++;
      end
    end
    drive(0, 0, 0, 0);
    chk("rand_writes", bad, 0);
    chk("rand_sent", sent, DEPTH);
    chk("rand_count", frame_count, 4);
    chk("rand_ready", ready, 1);
`ifdef FB_WRITER_CHECKSUM_EN
    chk("frame_sum", frame_sum, 7 * DEPTH);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
